// File: rtl/haraka_pkg.sv
// Shared definitions for the Haraka round-constant sequencer.
//   RC_WIDTH / NUM_RC  : constant width and table depth
//   STRIDE_512/256     : constants consumed per round in each mode
//   RC_TABLE           : the 40 Haraka v2 round constants, entry 0 first
//   mode_e, seq_state_e: mode select and sequencer state encodings
//   rc_base()          : first table index used by a given round
package haraka_pkg;

  localparam int RC_WIDTH   = 128;
  localparam int NUM_RC     = 40;
  localparam int IDX_W      = 6;
  localparam int STRIDE_512 = 8;
  localparam int STRIDE_256 = 4;

  typedef enum logic {
    MODE_512 = 1'b0,
    MODE_256 = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } seq_state_e;

  localparam logic [RC_WIDTH-1:0] RC_TABLE [NUM_RC] = '{
    128'h0684704c_e620c00a_b2c5fef0_75817b9d,
    128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
    128'h3402de2d_53f28498_cf029d60_9f029114,
    128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
    128'hcbcfb0cb_4872448b_79eecd1c_be397044,
    128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
    128'h67c28f43_5e2e7cd0_e2412761_da4fef1b,
    128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
    128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee,
    128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
    128'hb2cc0bb9_941723bf_69028b2e_8df69800,
    128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
    128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4,
    128'h1ea10344_f449a236_32d611ae_bb6a12ee,
    128'haf044988_4b050084_5f9600c9_9ca8eca6,
    128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
    128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173,
    128'h6260700d_6186b017_37f2efd9_10307d6b,
    128'h5aca45c2_21300443_81c29153_f6fc9ac6,
    128'h9223973c_226b68bb_2caf92e8_36d1943a,
    128'hd3bf9238_225886eb_6cbab958_e51071b4,
    128'hdb863ce5_aef0c677_933dfddd_24e1128d,
    128'hbb606268_ffeba09c_83e48de3_cb2212b1,
    128'h734bd3dc_e2e4d19c_2db91a4e_c72bf77d,
    128'h43bb47c3_61301b43_4b1415c4_2cb3924e,
    128'hdba775a8_e707eff6_03b231dd_16eb6899,
    128'h6df3614b_3c755977_8e5e2302_7eca472c,
    128'hcda75a17_d6de7d77_6d1be5b9_b88617f9,
    128'hec6b43f0_6ba8e9aa_9d6c069d_a946ee5d,
    128'hcb1e6950_f957332b_a2531159_3bf327c1,
    128'h2cee0c75_00da619c_e4ed0353_600ed0d9,
    128'hf0b1a5a1_96e90cab_80bbbabc_63a4a350,
    128'hae3db102_5e962988_ab0dde30_938dca39,
    128'h17bb8f38_d554a40b_8814f3a8_2e75b442,
    128'h34bb8a5b_5f427fd7_aeb6b779_360a16f6,
    128'h26f65241_cbe55438_43ce5918_ffbaafde,
    128'h4ce99a54_b9f3026a_a2ca9cf7_839ec978,
    128'hae51a51a_1bdff7be_40c06e28_22901235,
    128'ha0c1613c_ba7ed22b_c173bc0f_48a659cf,
    128'h756acc03_02288288_4ad6bdfd_e9c59da1
  };

  // Round r starts at r*8 in 512 mode and r*4 in 256 mode; 6-bit result.
  function automatic logic [IDX_W-1:0] rc_base(input logic [2:0] r, input mode_e m);
    return (m == MODE_256) ? {1'b0, r, 2'b00} : {r, 3'b000};
  endfunction

endpackage

// File: rtl/haraka_rc_rom.sv
// Combinational constant lookup.
//   idx    : 6-bit table index
//   rc_val : RC_TABLE[idx], or zero when idx is past the end of the table
module haraka_rc_rom
  import haraka_pkg::*;
(
  input  logic [IDX_W-1:0]    idx,
  output logic [RC_WIDTH-1:0] rc_val
);

  always_comb begin
    rc_val = '0;
    if (idx < IDX_W'(NUM_RC)) rc_val = RC_TABLE[idx];
  end

endmodule

// File: rtl/haraka_rc_sequencer.sv
// Round-constant sequencer for the Haraka permutation core. On start it
// walks rounds 0..NUM_ROUNDS-1 and presents one registered bank of
// constants per round to the AES datapath.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, honoured only when idle
//   mode       : sampled on start; 0 = Haraka-512 (8/round), 1 = Haraka-256 (4/round)
//   rc_valid   : rc / round / last_round are valid
//   rc_ready   : consumer accepts the current bank
//   rc         : constant bank, constant k at [k*RC_WIDTH +: RC_WIDTH]
//   round      : round index being presented
//   last_round : with rc_valid, marks round NUM_ROUNDS-1
//   busy       : high from the accepted start until done
//   done       : one-cycle pulse after the last bank is accepted
// Build option: define HARAKA_RC_PREFETCH_EN to add a shadow bank that is
// swapped in on accept, giving one round per cycle with rc_ready held high.
//
// Handshake: a bank is transferred on a cycle where rc_valid && rc_ready.
// Once rc_valid is raised, rc, round and last_round stay frozen and rc_valid
// stays high until that transfer happens.
module haraka_rc_sequencer
  import haraka_pkg::*;
#(
  parameter int NUM_ROUNDS       = 5,
  parameter int RC_WIDTH         = 128,
  parameter int MAX_RC_PER_ROUND = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 mode,
  output logic                                 rc_valid,
  input  logic                                 rc_ready,
  output logic [MAX_RC_PER_ROUND*RC_WIDTH-1:0] rc,
  output logic [2:0]                           round,
  output logic                                 last_round,
  output logic                                 busy,
  output logic                                 done
);

  localparam int         BANK_W = MAX_RC_PER_ROUND * RC_WIDTH;
  localparam logic [2:0] LAST   = 3'(NUM_ROUNDS - 1);

  seq_state_e        state, state_next;
  mode_e             mode_q;
  logic              accept;
  logic [IDX_W-1:0]  cur_base;
  logic [BANK_W-1:0] cur_bank;

  assign accept   = rc_valid & rc_ready;
  assign cur_base = rc_base(round, mode_q);

  // Bank for the current round; slots beyond stride 4 are blanked in 256 mode.
  for (genvar k = 0; k < MAX_RC_PER_ROUND; k++) begin : g_cur
    logic [RC_WIDTH-1:0] val;
    haraka_rc_rom u_rom (.idx(cur_base + IDX_W'(k)), .rc_val(val));
    assign cur_bank[k*RC_WIDTH +: RC_WIDTH] =
      (k >= STRIDE_256 && mode_q == MODE_256) ? '0 : val;
  end

`ifdef HARAKA_RC_PREFETCH_EN
  // Shadow holds the bank for the round after the one on rc. In LOAD that is
  // round+1; on an accept it is refilled with round+2 as rc takes round+1.
  logic [2:0]        shadow_round;
  logic [IDX_W-1:0]  shadow_base;
  logic [BANK_W-1:0] shadow_bank;
  logic [BANK_W-1:0] shadow;

  assign shadow_round = (state == ST_LOAD) ? round + 3'd1 : round + 3'd2;
  assign shadow_base  = rc_base(shadow_round, mode_q);

  for (genvar k = 0; k < MAX_RC_PER_ROUND; k++) begin : g_shadow
    logic [RC_WIDTH-1:0] val;
    haraka_rc_rom u_rom (.idx(shadow_base + IDX_W'(k)), .rc_val(val));
    assign shadow_bank[k*RC_WIDTH +: RC_WIDTH] =
      (k >= STRIDE_256 && mode_q == MODE_256) ? '0 : val;
  end

  always_ff @(posedge clk) begin
    if (rst || state == ST_FINISH) begin
      shadow <= '0;
    end else if (state == ST_LOAD || (state == ST_PRESENT && accept && round != LAST)) begin
      shadow <= shadow_bank;
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_LOAD;
      ST_LOAD:    state_next = ST_PRESENT;
      ST_PRESENT: begin
        if (accept) begin
          if (round == LAST) state_next = ST_FINISH;
`ifdef HARAKA_RC_PREFETCH_EN
          else state_next = ST_PRESENT;
`else
          else state_next = ST_LOAD;
`endif
        end
      end
      ST_FINISH:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_512;
      rc_valid   <= 1'b0;
      rc         <= '0;
      round      <= '0;
      last_round <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode_e'(mode);
            round  <= '0;
            busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          rc         <= cur_bank;
          rc_valid   <= 1'b1;
          last_round <= (round == LAST);
        end
        ST_PRESENT: begin
          if (accept) begin
            if (round == LAST) begin
              rc_valid   <= 1'b0;
              last_round <= 1'b0;
            end else begin
              round <= round + 3'd1;
`ifdef HARAKA_RC_PREFETCH_EN
              rc         <= shadow;
              last_round <= (round + 3'd1 == LAST);
`else
              rc_valid   <= 1'b0;
              last_round <= 1'b0;
`endif
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          round <= '0;
        end
        default: ;
      endcase
    end
  end

  // Flags a round count that would read past the 40-entry table.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_LOAD) begin
      assert (NUM_ROUNDS >= 1 && NUM_ROUNDS <= 5 &&
              int'(cur_base) + ((mode_q == MODE_256) ? STRIDE_256 : STRIDE_512) <= NUM_RC)
        else $error("haraka_rc_sequencer: round %0d indexes past the constant table", round);
    end
  end

endmodule

// File: tb/tb_haraka_rc_sequencer.sv
// Bench for haraka_rc_sequencer: directed sequences in both modes, with
// backpressure, ignored starts, mid-sequence reset and random rc_ready.
module tb_haraka_rc_sequencer;
  import haraka_pkg::*;

  localparam int N  = 5;
  localparam int W  = 128;
  localparam int M  = 8;
  localparam int BW = M * W;

`ifdef HARAKA_RC_PREFETCH_EN
  localparam int EXP_DONE_LAT = N + 3;
  localparam int EXP_RUN      = N;
`else
  localparam int EXP_DONE_LAT = 2 * N + 2;
  localparam int EXP_RUN      = 1;
`endif

  localparam logic [W-1:0] LIT_IDX0  = 128'h0684704ce620c00ab2c5fef075817b9d;
  localparam logic [W-1:0] LIT_IDX7  = 128'h2924d9b0afcacc07675ffde21fc70b3b;
  localparam logic [W-1:0] LIT_IDX39 = 128'h756acc03022882884ad6bdfde9c59da1;
  localparam logic [W-1:0] LIT_IDX4  = 128'hcbcfb0cb4872448b79eecd1cbe397044;
  localparam logic [W-1:0] LIT_IDX19 = 128'h9223973c226b68bb2caf92e836d1943a;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          rc_ready = 1'b0;
  logic          rc_valid, last_round, busy, done;
  logic [BW-1:0] rc;
  logic [2:0]    round;

  always #5 clk = ~clk;

  haraka_rc_sequencer #(.NUM_ROUNDS(N), .RC_WIDTH(W), .MAX_RC_PER_ROUND(M)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .rc_valid(rc_valid), .rc_ready(rc_ready), .rc(rc), .round(round),
    .last_round(last_round), .busy(busy), .done(done)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            passed = 0;
  logic [BW-1:0] exp_q[$];
  int            exp_round_q[$];
  int            ready_policy = 0;
  logic [BW-1:0] cap_bank [8];
  logic          cap_lr [8];

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_rc(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_bank(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else begin
      for (int k = 0; k < M; k++) begin
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s: constant %0d is %h, expected %h (cycle %0d)",
                   name, k, act[k*W +: W], exp[k*W +: W], cyc);
          break;
        end
      end
    end
  endtask

  // Expected bank from the table rule: slot k holds table[r*stride + k].
  function automatic logic [BW-1:0] model_bank(input int m, input int r);
    logic [BW-1:0] b;
    int stride;
    b = '0;
    stride = (m == 1) ? 4 : 8;
    for (int k = 0; k < stride; k++) b[k*W +: W] = RC_TABLE[6'(r * stride + k)];
    return b;
  endfunction

  task automatic push_sequence(input int m);
    for (int r = 0; r < N; r++) begin
      exp_q.push_back(model_bank(m, r));
      exp_round_q.push_back(r);
    end
  endtask

  // Accept tracking at the active edge.
  logic          hold_pending = 1'b0;
  logic [BW-1:0] held_rc = '0;
  logic [2:0]    held_round = '0;
  initial forever begin
    @(posedge clk);
    if (rst) hold_pending = 1'b0;
    else begin
      hold_pending = rc_valid && !rc_ready;
      held_rc      = rc;
      held_round   = round;
      if (rc_valid && rc_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_round_q.pop_front());
      end
    end
  end

  // Output compare on the inactive edge.
  logic prev_done = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rc_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid: rc_valid=1 round=%0d with no bank expected (cycle %0d)", round, cyc);
        end else begin
          check_bank("bank", rc, exp_q[0]);
          check_int("round", int'(round), exp_round_q[0]);
          check_int("last_round", int'(last_round), (exp_round_q[0] == N - 1) ? 1 : 0);
          check_int("busy_with_valid", int'(busy), 1);
        end
      end else begin
        check_int("last_round_without_valid", int'(last_round), 0);
      end
      if (hold_pending) begin
        check_int("hold_valid", int'(rc_valid), 1);
        check_bank("hold_rc", rc, held_rc);
        check_int("hold_round", int'(round), int'(held_round));
      end
      if (done) begin
        check_int("done_after_all_banks", exp_q.size(), 0);
        check_int("done_busy_low", int'(busy), 0);
        check_int("done_single_cycle", int'(prev_done), 0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
    case (ready_policy)
      0:       rc_ready = 1'b1;
      1:       rc_ready = 1'($urandom_range(0, 1));
      default: rc_ready = 1'b0;
    endcase
  endtask

  // Returns the index of the cycle in which start was high.
  task automatic start_seq(input int m, output int ts);
    start = 1'b1;
    mode  = 1'(m);
    push_sequence(m);
    @(posedge clk);
    #1;
    ts    = cyc - 1;
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_seq(input int m, input int budget,
                         output int lat_valid, output int lat_done, output int max_run);
    int ts, run;
    lat_valid = -1;
    lat_done  = -1;
    max_run   = 0;
    run       = 0;
    for (int r = 0; r < 8; r++) begin
      cap_bank[r] = '0;
      cap_lr[r]   = 1'b0;
    end
    start_seq(m, ts);
    for (int i = 0; i < budget; i++) begin
      step();
      if (rc_valid) begin
        if (lat_valid < 0) lat_valid = cyc - ts;
        cap_bank[round] = rc;
        cap_lr[round]   = last_round;
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (done) begin
        lat_done = cyc - ts;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      step();
      if (done) got = 1;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lv, ld, mr, ts, got, saw;
    logic [BW-1:0] bp_rc;

    repeat (3) step();
    check_int("reset_rc_valid", int'(rc_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_round", int'(round), 0);
    check_int("reset_last_round", int'(last_round), 0);
    check_bank("reset_rc", rc, '0);
    rst = 1'b0;
    step();

    // 512 mode, rc_ready high.
    ready_policy = 0;
    run_seq(0, 60, lv, ld, mr);
    check_int("m512_valid_latency", lv, 2);
    check_int("m512_done_latency", ld, EXP_DONE_LAT);
    check_int("m512_valid_run", mr, EXP_RUN);
    check_rc("m512_r0_rc0", cap_bank[0][0*W +: W], LIT_IDX0);
    check_rc("m512_r0_rc7", cap_bank[0][7*W +: W], LIT_IDX7);
    check_rc("m512_r4_rc7", cap_bank[4][7*W +: W], LIT_IDX39);
    check_int("m512_r4_last", int'(cap_lr[4]), 1);
    check_int("m512_r3_last", int'(cap_lr[3]), 0);

    // 256 mode, rc_ready high.
    run_seq(1, 60, lv, ld, mr);
    check_int("m256_valid_latency", lv, 2);
    check_int("m256_done_latency", ld, EXP_DONE_LAT);
    check_rc("m256_r1_rc0", cap_bank[1][0*W +: W], LIT_IDX4);
    check_rc("m256_r1_rc7_4", cap_bank[1][4*W +: W] | cap_bank[1][5*W +: W] |
                              cap_bank[1][6*W +: W] | cap_bank[1][7*W +: W], '0);
    check_rc("m256_r4_rc3", cap_bank[4][3*W +: W], LIT_IDX19);

    // Backpressure in round 2 with start pulses while busy.
    ready_policy = 0;
    start_seq(0, ts);
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (rc_valid && round == 3'd2) got = 1;
    end
    check_int("bp_reached_round2", got, 1);
    ready_policy = 2;
    rc_ready     = 1'b0;
    bp_rc        = rc;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      mode  = 1'b1;
      step();
    end
    start = 1'b0;
    check_int("bp_round_held", int'(round), 2);
    check_bank("bp_rc_held", rc, bp_rc);
    ready_policy = 0;
    rc_ready     = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step();
      if (rc_valid && round != 3'd2) got = 1;
    end
    check_int("bp_next_round", int'(round), 3);
    wait_done(40, got);
    check_int("bp_done", got, 1);
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rc_valid || busy) saw++;
    end
    check_int("bp_start_not_queued", saw, 0);

    // Reset in round 3.
    start_seq(0, ts);
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (rc_valid && round == 3'd3) got = 1;
    end
    check_int("rst_reached_round3", got, 1);
    rst = 1'b1;
    exp_q.delete();
    exp_round_q.delete();
    step();
    check_int("rst_rc_valid", int'(rc_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_round", int'(round), 0);
    check_bank("rst_rc", rc, '0);
    check_int("rst_done", int'(done), 0);
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || rc_valid) saw++;
    end
    check_int("rst_no_done", saw, 0);
    run_seq(0, 60, lv, ld, mr);
    check_int("rst_restart_valid_latency", lv, 2);
    check_int("rst_restart_done_latency", ld, EXP_DONE_LAT);
    check_rc("rst_restart_r0_rc0", cap_bank[0][0*W +: W], LIT_IDX0);

    // Random rc_ready in both modes.
    ready_policy = 1;
    for (int rep = 0; rep < 4; rep++) begin
      run_seq(rep % 2, 300, lv, ld, mr);
      check_int("rand_done_seen", (ld > 0) ? 1 : 0, 1);
    end
    ready_policy = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
